// File: rtl/audio_lj_stream.sv
// rtl/audio_lj_stream.sv - stereo left-justified codec master with capture/playback sample FIFOs
module audio_lj_stream #(
  parameter int DATA_WIDTH = 24,
  parameter int SLOT_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  BCLK,
  output logic                  ADCLRC,
  output logic                  DACLRC,
  input  logic                  ADCDAT,
  output logic                  DACDAT,
  input  logic                  loopback,
  output logic                  cap_valid,
  input  logic                  cap_ready,
  output logic [DATA_WIDTH-1:0] cap_left,
  output logic [DATA_WIDTH-1:0] cap_right,
  input  logic                  play_valid,
  output logic                  play_ready,
  input  logic [DATA_WIDTH-1:0] play_left,
  input  logic [DATA_WIDTH-1:0] play_right,
  input  logic                  clr_flags,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int BW = $clog2(2 * SLOT_WIDTH);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int FW = 2 * DATA_WIDTH;
  localparam logic [BW-1:0] B_LAST   = BW'(2 * SLOT_WIDTH - 1);
  localparam logic [BW-1:0] SW_B     = BW'(SLOT_WIDTH);
  localparam logic [BW-1:0] DW_B     = BW'(DATA_WIDTH);
  localparam logic [BW-1:0] CAP_LAST = BW'(SLOT_WIDTH + DATA_WIDTH - 1);
  localparam logic [BW-1:0] B_ONE    = BW'(1);
  localparam logic [AW:0]   P_ONE    = (AW + 1)'(1);

  // Bit clock / frame position state
  logic          bclk_q;
  logic          lrc_q;
  logic [BW-1:0] b_q;

  // Serial data paths
  logic                  dacdat_q;
  logic [DATA_WIDTH-1:0] dac_sh_q;
  logic [DATA_WIDTH-1:0] out_right_q;
  logic [DATA_WIDTH-1:0] adc_l_q;
  logic [DATA_WIDTH-1:0] adc_r_q;
  logic                  push_pend_q;

  // Control / status
  logic loopback_q;
  logic overflow_q;
  logic underflow_q;

  // FIFO storage (one entry = one stereo frame {left, right})
  logic [FW-1:0] cap_mem  [FIFO_DEPTH];
  logic [FW-1:0] play_mem [FIFO_DEPTH];
  logic [AW:0]   cap_wr_q, cap_rd_q;
  logic [AW:0]   play_wr_q, play_rd_q;

  // Frame position decode
  logic          rise, fall, frame_start;
  logic          cur_left, nxt_left;
  logic [BW-1:0] b_nxt, cur_k, nxt_k;

  assign rise        = ~bclk_q;
  assign fall        = bclk_q;
  assign b_nxt       = (b_q == B_LAST) ? '0 : b_q + B_ONE;
  assign cur_left    = (b_q < SW_B);
  assign cur_k       = cur_left ? b_q : b_q - SW_B;
  assign nxt_left    = (b_nxt < SW_B);
  assign nxt_k       = nxt_left ? b_nxt : b_nxt - SW_B;
  assign frame_start = fall & (b_q == B_LAST);

  // FIFO status
  logic          cap_empty, cap_full, play_empty, play_full;
  logic [FW-1:0] cap_head, play_head;

  assign cap_empty  = (cap_wr_q == cap_rd_q);
  assign cap_full   = (cap_wr_q[AW] != cap_rd_q[AW]) && (cap_wr_q[AW-1:0] == cap_rd_q[AW-1:0]);
  assign play_empty = (play_wr_q == play_rd_q);
  assign play_full  = (play_wr_q[AW] != play_rd_q[AW]) && (play_wr_q[AW-1:0] == play_rd_q[AW-1:0]);
  assign cap_head   = cap_mem[cap_rd_q[AW-1:0]];
  assign play_head  = play_mem[play_rd_q[AW-1:0]];

  // Transfer decisions; in loopback the external stream ports are closed
  logic                  lb_move, cap_pop, cap_push, cap_drop;
  logic                  play_push, play_pop, play_starve;
  logic [FW-1:0]         play_din;
  logic [DATA_WIDTH-1:0] frame_left, frame_right, dac_slot_word;

  assign lb_move     = loopback_q & ~cap_empty & ~play_full;
  assign cap_valid   = ~loopback_q & ~cap_empty;
  assign cap_pop     = (cap_valid & cap_ready) | lb_move;
  assign cap_push    = push_pend_q & (~cap_full | cap_pop);
  assign cap_drop    = push_pend_q & cap_full & ~cap_pop;
  assign play_ready  = ~loopback_q & ~play_full;
  assign play_push   = lb_move | (play_valid & play_ready);
  assign play_din    = lb_move ? cap_head : {play_left, play_right};
  assign play_pop    = frame_start & ~play_empty;
  assign play_starve = frame_start & play_empty;

  // An empty playback FIFO at frame start plays a silent frame
  assign frame_left    = play_empty ? '0 : play_head[FW-1:DATA_WIDTH];
  assign frame_right   = play_empty ? '0 : play_head[DATA_WIDTH-1:0];
  assign dac_slot_word = nxt_left ? frame_left : out_right_q;

  assign BCLK      = bclk_q;
  assign ADCLRC    = lrc_q;
  assign DACLRC    = lrc_q;
  assign DACDAT    = dacdat_q;
  assign cap_left  = cap_head[FW-1:DATA_WIDTH];
  assign cap_right = cap_head[DATA_WIDTH-1:0];
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

  // Bit clock divider, frame counter and LR clock, all stepped on the falling bit clock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bclk_q <= 1'b0;
      b_q    <= '0;
      lrc_q  <= 1'b1;
    end else begin
      bclk_q <= ~bclk_q;
      if (fall) begin
        b_q   <= b_nxt;
        lrc_q <= nxt_left;
      end
    end
  end

  // ADC deserialiser: sample on rising bit clock, request a push one clk after the last right bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      adc_l_q     <= '0;
      adc_r_q     <= '0;
      push_pend_q <= 1'b0;
    end else begin
      push_pend_q <= rise & (b_q == CAP_LAST);
      if (rise && (cur_k < DW_B)) begin
        if (cur_left) adc_l_q <= {adc_l_q[DATA_WIDTH-2:0], ADCDAT};
        else          adc_r_q <= {adc_r_q[DATA_WIDTH-2:0], ADCDAT};
      end
    end
  end

  // DAC serialiser: load a slot word at slot start, shift MSB first, pad the slot tail with zeros
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dacdat_q    <= 1'b0;
      dac_sh_q    <= '0;
      out_right_q <= '0;
    end else if (fall) begin
      if (frame_start) out_right_q <= frame_right;
      if (nxt_k == '0) begin
        dacdat_q <= dac_slot_word[DATA_WIDTH-1];
        dac_sh_q <= {dac_slot_word[DATA_WIDTH-2:0], 1'b0};
      end else if (nxt_k < DW_B) begin
        dacdat_q <= dac_sh_q[DATA_WIDTH-1];
        dac_sh_q <= {dac_sh_q[DATA_WIDTH-2:0], 1'b0};
      end else begin
        dacdat_q <= 1'b0;
      end
    end
  end

  // Capture FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_wr_q <= '0;
      cap_rd_q <= '0;
    end else begin
      if (cap_push) cap_wr_q <= cap_wr_q + P_ONE;
      if (cap_pop)  cap_rd_q <= cap_rd_q + P_ONE;
    end
  end

  // Capture FIFO storage
  always_ff @(posedge clk) begin
    if (cap_push) cap_mem[cap_wr_q[AW-1:0]] <= {adc_l_q, adc_r_q};
  end

  // Playback FIFO pointers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      play_wr_q <= '0;
      play_rd_q <= '0;
    end else begin
      if (play_push) play_wr_q <= play_wr_q + P_ONE;
      if (play_pop)  play_rd_q <= play_rd_q + P_ONE;
    end
  end

  // Playback FIFO storage
  always_ff @(posedge clk) begin
    if (play_push) play_mem[play_wr_q[AW-1:0]] <= play_din;
  end

  // Loopback mode latched at frame start; sticky flags where a set beats a clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loopback_q  <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (frame_start) loopback_q <= loopback;
      if (cap_drop)       overflow_q <= 1'b1;
      else if (clr_flags) overflow_q <= 1'b0;
      if (play_starve)    underflow_q <= 1'b1;
      else if (clr_flags) underflow_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_audio_lj_stream.sv
// tb/tb_audio_lj_stream.sv - randomized bench for audio_lj_stream against a queue-based frame model
module tb_audio_lj_stream;

  localparam int DW = 24;
  localparam int SW = 32;
  localparam int D  = 4;
  localparam int FB = 2 * SW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          BCLK, ADCLRC, DACLRC, DACDAT;
  logic          ADCDAT = 1'b0;
  logic          loopback = 1'b0;
  logic          cap_valid;
  logic          cap_ready = 1'b0;
  logic [DW-1:0] cap_left, cap_right;
  logic          play_valid = 1'b0;
  logic          play_ready;
  logic [DW-1:0] play_left = '0;
  logic [DW-1:0] play_right = '0;
  logic          clr_flags = 1'b0;
  logic          overflow, underflow;

  audio_lj_stream #(.DATA_WIDTH(DW), .SLOT_WIDTH(SW), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n), .BCLK(BCLK), .ADCLRC(ADCLRC), .DACLRC(DACLRC),
    .ADCDAT(ADCDAT), .DACDAT(DACDAT), .loopback(loopback),
    .cap_valid(cap_valid), .cap_ready(cap_ready), .cap_left(cap_left), .cap_right(cap_right),
    .play_valid(play_valid), .play_ready(play_ready), .play_left(play_left), .play_right(play_right),
    .clr_flags(clr_flags), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: clk edges since reset, queues of stereo frames, current DAC frame, flags
  int unsigned   n;
  logic [47:0]   q_play[$];
  logic [47:0]   q_cap[$];
  logic [DW-1:0] m_dac_l, m_dac_r;
  bit            m_lbq, m_ovf, m_unf;

  // ADC source: frame being transmitted, chosen at each frame start
  int            adc_mode = 0;
  logic [DW-1:0] adc_tx_l = '0, adc_tx_r = '0;
  logic [DW-1:0] ramp = 1;
  logic [DW-1:0] fix_l = 24'h800001, fix_r = 24'h7FFFFF;

  // Playback source frames, head is what play_left/right currently offer
  logic [47:0] src_q[$];
  bit          src_adv;

  function automatic logic [47:0] rand48();
    return {24'($urandom), 24'($urandom)};
  endfunction

  task automatic model_reset();
    n = 0;
    q_play.delete();
    q_cap.delete();
    m_dac_l = '0;
    m_dac_r = '0;
    m_lbq = 0;
    m_ovf = 0;
    m_unf = 0;
  endtask

  task automatic check_outputs();
    int b = int'((n / 2) % FB);
    int k = b % SW;
    logic [DW-1:0] s;
    logic exp_d;
    bit cv;
    s = (b < SW) ? m_dac_l : m_dac_r;
    exp_d = (k < DW) ? s[DW-1-k] : 1'b0;
    cv = !m_lbq && (q_cap.size() > 0);
    check("bclk", 64'(BCLK), 64'(n % 2));
    check("adclrc", 64'(ADCLRC), 64'(b < SW));
    check("daclrc", 64'(DACLRC), 64'(b < SW));
    check("dacdat", 64'(DACDAT), 64'(exp_d));
    check("cap_valid", 64'(cap_valid), 64'(cv));
    if (cv) check("cap_data", 64'({cap_left, cap_right}), 64'(q_cap[0]));
    check("play_ready", 64'(play_ready), 64'(!m_lbq && (q_play.size() < D)));
    check("overflow", 64'(overflow), 64'(m_ovf));
    check("underflow", 64'(underflow), 64'(m_unf));
  endtask

  task automatic drive_adc();
    if (n % 2 == 0) begin
      int b = int'((n / 2) % FB);
      int k = b % SW;
      if (b == 0) begin
        case (adc_mode)
          1: begin adc_tx_l = fix_l; adc_tx_r = fix_r; end
          2: begin adc_tx_l = ramp; adc_tx_r = ramp + 24'h100000; ramp = ramp + 1; end
          default: begin adc_tx_l = 24'($urandom); adc_tx_r = 24'($urandom); end
        endcase
      end
      if (k < DW) ADCDAT = (b < SW) ? adc_tx_l[DW-1-k] : adc_tx_r[DW-1-k];
      else        ADCDAT = 1'($urandom);
    end
  endtask

  // Apply the effects of the coming clk edge to the model, from pre-edge state and current inputs
  task automatic model_edge();
    bit is_rise = (n % 2) == 0;
    int b = int'((n / 2) % FB);
    bit fs = !is_rise && (b == FB - 1);
    bit push_ev = !is_rise && (b == SW + DW - 1);
    bit cap_v = !m_lbq && (q_cap.size() > 0);
    bit lb = m_lbq && (q_cap.size() > 0) && (q_play.size() < D);
    bit p_rdy = !m_lbq && (q_play.size() < D);
    bit set_o = 0;
    bit set_u = 0;
    logic [47:0] moved = '0;
    if ((cap_v && cap_ready) || lb) moved = q_cap.pop_front();
    if (push_ev) begin
      if (q_cap.size() < D) q_cap.push_back({adc_tx_l, adc_tx_r});
      else set_o = 1;
    end
    if (fs) begin
      if (q_play.size() > 0) {m_dac_l, m_dac_r} = q_play.pop_front();
      else begin m_dac_l = '0; m_dac_r = '0; set_u = 1; end
      m_lbq = loopback;
    end
    if (lb) q_play.push_back(moved);
    else if (play_valid && p_rdy) begin
      q_play.push_back({play_left, play_right});
      src_adv = 1;
    end
    if (set_o) m_ovf = 1; else if (clr_flags) m_ovf = 0;
    if (set_u) m_unf = 1; else if (clr_flags) m_unf = 0;
    n++;
  endtask

  task automatic step();
    logic [47:0] h;
    src_adv = 0;
    if (rst_n) begin
      drive_adc();
      model_edge();
    end
    @(negedge clk);
    check_outputs();
    if (src_adv) begin
      void'(src_q.pop_front());
      if (src_q.size() == 0) src_q.push_back(rand48());
    end
    h = src_q[0];
    play_left  = h[47:24];
    play_right = h[23:0];
  endtask

  task automatic run(input int cycles, input int pv, input int cr, input int clr);
    for (int i = 0; i < cycles; i++) begin
      play_valid = ($urandom_range(99) < pv);
      cap_ready  = ($urandom_range(99) < cr);
      clr_flags  = ($urandom_range(99) < clr);
      step();
    end
    clr_flags = 1'b0;
  endtask

  task automatic reset_mid();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs();
    repeat (3) begin
      @(negedge clk);
      check_outputs();
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [47:0] h;
    src_q.push_back(48'hA5A5A5_5A5A5A);
    src_q.push_back(48'hFFFFFF_000001);
    h = src_q[0];
    play_left  = h[47:24];
    play_right = h[23:0];
    model_reset();
    repeat (3) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;

    // Idle after reset: silent frame 0, underflow from frame 1 onward, then a clear
    run(300, 0, 0, 0);
    run(1, 0, 0, 100);
    run(20, 0, 0, 0);

    // Fixed ADC pattern with a free-flowing consumer; playback starts with A5A5A5/5A5A5A
    adc_mode = 1;
    run(800, 100, 100, 0);

    // Consumer stalled long enough to fill the capture FIFO and drop frames
    run(700, 50, 0, 0);
    run(1, 50, 0, 100);
    run(300, 50, 100, 0);

    // Random traffic with occasional flag clears
    adc_mode = 0;
    run(1300, 40, 60, 2);

    // Drain playback, then loopback enabled mid-frame with an ADC ramp
    run(650, 0, 100, 0);
    adc_mode = 2;
    ramp = 1;
    loopback = 1'b1;
    run(60, 0, 100, 0);
    run(900, 50, 50, 0);
    loopback = 1'b0;
    run(700, 50, 100, 0);

    // Asynchronous reset mid-frame with data in flight
    adc_mode = 0;
    run(230, 100, 0, 0);
    reset_mid();
    run(500, 50, 50, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
